// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush, NOP insertion on empty slots and a saturating bubble counter.
module if_id_skid_reg #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013),
  parameter int              SKID      = 1,
  parameter int              CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             VALID_IF,
  output logic             READY_IF,
  input  logic [XLEN-1:0]  DOUT2_IF,
  input  logic [XLEN-1:0]  ADDR_IF,
  input  logic [XLEN-1:0]  N_ADDR_IF,
  output logic             VALID_ID,
  input  logic             READY_ID,
  output logic [XLEN-1:0]  IR_ID,
  output logic [XLEN-1:0]  ADDR_ID,
  output logic [XLEN-1:0]  N_ADDR_ID,
  output logic [CNT_W-1:0] BUBBLE_CNT
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              in_fire;
  logic              out_fire;
  logic              ready_int;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;
  logic [XLEN-1:0]   main_ir;
  logic [XLEN-1:0]   main_addr;
  logic [XLEN-1:0]   main_naddr;
  logic [XLEN-1:0]   skid_ir;
  logic [XLEN-1:0]   skid_addr;
  logic [XLEN-1:0]   skid_naddr;
  logic [CNT_W-1:0]  bubble_q;

  assign VALID_ID   = (state != ST_EMPTY);
  assign IR_ID      = VALID_ID ? main_ir : NOP_INSTR;
  assign ADDR_ID    = main_addr;
  assign N_ADDR_ID  = main_naddr;
  assign BUBBLE_CNT = bubble_q;
  assign READY_IF   = ready_int;

  assign in_fire  = VALID_IF & ready_int;
  assign out_fire = VALID_ID & READY_ID;

  // With the skid buffer, READY_IF is a flop so decode back-pressure never reaches fetch combinationally.
  generate
    if (SKID != 0) begin : g_ready_reg
      logic ready_q;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_nxt != ST_SKID);
        end
      end

      assign ready_int = ready_q;
    end else begin : g_ready_comb
      assign ready_int = ~VALID_ID | READY_ID;
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Flush wins over every handshake; an out_fire in the flush cycle still counts as consumed.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (FLUSH) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state_nxt    = ST_FULL;
            load_main_in = 1'b1;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire && (SKID != 0)) begin
            state_nxt = ST_SKID;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            state_nxt      = ST_FULL;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      main_ir    <= NOP_INSTR;
      main_addr  <= '0;
      main_naddr <= '0;
    end else if (load_main_in) begin
      main_ir    <= DOUT2_IF;
      main_addr  <= ADDR_IF;
      main_naddr <= N_ADDR_IF;
    end else if (load_main_skid) begin
      main_ir    <= skid_ir;
      main_addr  <= skid_addr;
      main_naddr <= skid_naddr;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      skid_ir    <= NOP_INSTR;
      skid_addr  <= '0;
      skid_naddr <= '0;
    end else if (load_skid) begin
      skid_ir    <= DOUT2_IF;
      skid_addr  <= ADDR_IF;
      skid_naddr <= N_ADDR_IF;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bubble_q <= '0;
    end else if (READY_ID && !VALID_ID && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_q <= bubble_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench for if_id_skid_reg: a SKID=1 and a SKID=0 instance share stimulus,
// each with its own fetch PC model, expected-beat queue and bubble model.
module tb_if_id_skid_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] npc;
  } beat_t;

  logic        CLK;
  logic        RST;
  logic        FLUSH;
  logic        VALID_IF;
  logic        READY_ID;

  logic [31:0] pc_a, pc_b;
  logic [31:0] din_a, din_b;
  logic        ready_a, ready_b;
  logic        valid_a, valid_b;
  logic [31:0] ir_a, ir_b, addr_a, addr_b, naddr_a, naddr_b;
  logic [3:0]  bubble_a, bubble_b;
  logic [3:0]  bub_model_a, bub_model_b;

  beat_t       q_a[$];
  beat_t       q_b[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic        prev_hold_a, prev_hold_b;
  logic [31:0] prev_ir_a, prev_ir_b, prev_addr_a, prev_addr_b;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    if (pc == 32'h0) return 32'h00500093;
    if (pc == 32'h4) return 32'h00A00113;
    return {pc[19:0], 12'h093};
  endfunction

  assign din_a = instr_of(pc_a);
  assign din_b = instr_of(pc_b);

  if_id_skid_reg #(.XLEN(32), .NOP_INSTR(NOP), .SKID(1), .CNT_W(4)) dut_a (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .VALID_IF(VALID_IF), .READY_IF(ready_a),
    .DOUT2_IF(din_a), .ADDR_IF(pc_a), .N_ADDR_IF(pc_a + 32'd4),
    .VALID_ID(valid_a), .READY_ID(READY_ID),
    .IR_ID(ir_a), .ADDR_ID(addr_a), .N_ADDR_ID(naddr_a),
    .BUBBLE_CNT(bubble_a)
  );

  if_id_skid_reg #(.XLEN(32), .NOP_INSTR(NOP), .SKID(0), .CNT_W(4)) dut_b (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .VALID_IF(VALID_IF), .READY_IF(ready_b),
    .DOUT2_IF(din_b), .ADDR_IF(pc_b), .N_ADDR_IF(pc_b + 32'd4),
    .VALID_ID(valid_b), .READY_ID(READY_ID),
    .IR_ID(ir_b), .ADDR_ID(addr_b), .N_ADDR_ID(naddr_b),
    .BUBBLE_CNT(bubble_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and take effect at the following edge.
  task automatic applyStimulus(input logic valid, input logic ready, input logic flush);
    VALID_IF = valid;
    READY_ID = ready;
    FLUSH    = flush;
    @(posedge CLK);
    #1;
  endtask

  // Fetch advances its PC only on an accepted beat; bubble models saturate at 15.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_a        <= '0;
      pc_b        <= '0;
      bub_model_a <= '0;
      bub_model_b <= '0;
    end else begin
      if (VALID_IF && ready_a) pc_a <= pc_a + 32'd4;
      if (VALID_IF && ready_b) pc_b <= pc_b + 32'd4;
      if (READY_ID && !valid_a && bub_model_a != 4'hF) bub_model_a <= bub_model_a + 4'd1;
      if (READY_ID && !valid_b && bub_model_b != 4'hF) bub_model_b <= bub_model_b + 4'd1;
    end
  end

  // Monitor: pop on out_fire, then drop everything on flush, otherwise push on in_fire.
  always @(negedge CLK) begin
    beat_t exp_beat;
    if (RST) begin
      q_a.delete();
      q_b.delete();
      prev_hold_a = 1'b0;
      prev_hold_b = 1'b0;
    end else begin
      if (prev_hold_a) begin
        checkOutput("hold_valid_a", {31'b0, valid_a}, 32'd1);
        checkOutput("hold_ir_a", ir_a, prev_ir_a);
        checkOutput("hold_addr_a", addr_a, prev_addr_a);
      end
      if (prev_hold_b) begin
        checkOutput("hold_valid_b", {31'b0, valid_b}, 32'd1);
        checkOutput("hold_ir_b", ir_b, prev_ir_b);
        checkOutput("hold_addr_b", addr_b, prev_addr_b);
      end

      if (valid_a && READY_ID) begin
        checkOutput("sb_nonempty_a", {31'b0, q_a.size() > 0}, 32'd1);
        if (q_a.size() > 0) begin
          exp_beat = q_a.pop_front();
          checkOutput("sb_ir_a", ir_a, exp_beat.ir);
          checkOutput("sb_addr_a", addr_a, exp_beat.pc);
          checkOutput("sb_naddr_a", naddr_a, exp_beat.npc);
        end
      end
      if (valid_b && READY_ID) begin
        checkOutput("sb_nonempty_b", {31'b0, q_b.size() > 0}, 32'd1);
        if (q_b.size() > 0) begin
          exp_beat = q_b.pop_front();
          checkOutput("sb_ir_b", ir_b, exp_beat.ir);
          checkOutput("sb_addr_b", addr_b, exp_beat.pc);
          checkOutput("sb_naddr_b", naddr_b, exp_beat.npc);
        end
      end

      if (FLUSH) begin
        q_a.delete();
        q_b.delete();
      end else begin
        if (VALID_IF && ready_a) q_a.push_back('{instr_of(pc_a), pc_a, pc_a + 32'd4});
        if (VALID_IF && ready_b) q_b.push_back('{instr_of(pc_b), pc_b, pc_b + 32'd4});
      end

      if (!valid_a) checkOutput("nop_a", ir_a, NOP);
      if (!valid_b) checkOutput("nop_b", ir_b, NOP);
      checkOutput("ready_comb_b", {31'b0, ready_b}, {31'b0, ~valid_b | READY_ID});
      checkOutput("bubble_a", {28'b0, bubble_a}, {28'b0, bub_model_a});
      checkOutput("bubble_b", {28'b0, bubble_b}, {28'b0, bub_model_b});

      prev_hold_a = valid_a && !READY_ID && !FLUSH;
      prev_hold_b = valid_b && !READY_ID && !FLUSH;
      prev_ir_a   = ir_a;
      prev_ir_b   = ir_b;
      prev_addr_a = addr_a;
      prev_addr_b = addr_b;
    end
  end

  initial begin
    RST      = 1'b1;
    FLUSH    = 1'b0;
    VALID_IF = 1'b0;
    READY_ID = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Stream a few beats, then hit reset between edges and look before any clock.
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("rst_valid_a", {31'b0, valid_a}, 32'd0);
    checkOutput("rst_ir_a", ir_a, NOP);
    checkOutput("rst_addr_a", addr_a, 32'd0);
    checkOutput("rst_naddr_a", naddr_a, 32'd0);
    checkOutput("rst_ready_a", {31'b0, ready_a}, 32'd1);
    checkOutput("rst_bubble_a", {28'b0, bubble_a}, 32'd0);
    checkOutput("rst_valid_b", {31'b0, valid_b}, 32'd0);
    checkOutput("rst_ir_b", ir_b, NOP);
    checkOutput("rst_addr_b", addr_b, 32'd0);
    VALID_IF = 1'b0;
    READY_ID = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Back-to-back stream from PC 0.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("s1_valid_a", {31'b0, valid_a}, 32'd1);
    checkOutput("s1_ir_a", ir_a, 32'h00500093);
    checkOutput("s1_addr_a", addr_a, 32'h0);
    checkOutput("s1_naddr_a", naddr_a, 32'h4);
    checkOutput("s1_ir_b", ir_b, 32'h00500093);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("s2_ir_a", ir_a, 32'h00A00113);
    checkOutput("s2_addr_a", addr_a, 32'h4);
    checkOutput("s2_naddr_a", naddr_a, 32'h8);
    checkOutput("s2_ir_b", ir_b, 32'h00A00113);
    checkOutput("s2_naddr_b", naddr_b, 32'h8);

    // Decode stalls two cycles: SKID=1 parks a beat in the skid entry and drops READY_IF.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("bp1_ready_a", {31'b0, ready_a}, 32'd0);
    checkOutput("bp1_ir_a", ir_a, 32'h00A00113);
    checkOutput("bp1_ready_b", {31'b0, ready_b}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("bp2_ready_a", {31'b0, ready_a}, 32'd0);
    checkOutput("bp2_ir_a", ir_a, 32'h00A00113);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("bp3_ir_a", ir_a, 32'h00008093);
    checkOutput("bp3_ready_a", {31'b0, ready_a}, 32'd1);
    checkOutput("bp3_ir_b", ir_b, 32'h00008093);

    // Refill the skid entry, then flush with fetch still presenting a beat.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pf_ready_a", {31'b0, ready_a}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("fl_valid_a", {31'b0, valid_a}, 32'd0);
    checkOutput("fl_ir_a", ir_a, NOP);
    checkOutput("fl_ready_a", {31'b0, ready_a}, 32'd1);
    checkOutput("fl_addr_a", addr_a, 32'h8);
    checkOutput("fl_valid_b", {31'b0, valid_b}, 32'd0);
    checkOutput("fl_ir_b", ir_b, NOP);
    checkOutput("fl_addr_b", addr_b, 32'h8);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("fl2_valid_a", {31'b0, valid_a}, 32'd0);

    // Idle with decode ready: bubble counter must saturate at 15.
    repeat (20) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("sat_a", {28'b0, bubble_a}, 32'd15);
    checkOutput("sat_b", {28'b0, bubble_b}, 32'd15);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("sat_hold_a", {28'b0, bubble_a}, 32'd15);

    // Random traffic with occasional flushes; the monitor does the checking.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(logic'($urandom_range(0, 3) != 0),
                    logic'($urandom_range(0, 2) != 0),
                    logic'($urandom_range(0, 24) == 0));
    end

    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("drain_a", q_a.size(), 32'd0);
    checkOutput("drain_b", q_b.size(), 32'd0);
    checkOutput("drain_valid_a", {31'b0, valid_a}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
